// File: rtl/lcd_timing_drv_pkg.sv
// Shared types and constants for the LCD timing driver: panel presets, RGB888 colours, counter width.
package lcd_timing_pkg;

  typedef logic [23:0] rgb888_t;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = 2047;

  // 480x272 panel preset (driver defaults)
  localparam int P480_H_SYNC  = 41;
  localparam int P480_H_BACK  = 2;
  localparam int P480_H_DISP  = 480;
  localparam int P480_H_FRONT = 2;
  localparam int P480_V_SYNC  = 10;
  localparam int P480_V_BACK  = 2;
  localparam int P480_V_DISP  = 272;
  localparam int P480_V_FRONT = 2;

  // 800x480 panel preset
  localparam int P800_H_SYNC  = 128;
  localparam int P800_H_BACK  = 88;
  localparam int P800_H_DISP  = 800;
  localparam int P800_H_FRONT = 40;
  localparam int P800_V_SYNC  = 2;
  localparam int P800_V_BACK  = 33;
  localparam int P800_V_DISP  = 480;
  localparam int P800_V_FRONT = 10;

  localparam rgb888_t WHITE = 24'hFF_FF_FF;
  localparam rgb888_t BLACK = 24'h00_00_00;
  localparam rgb888_t RED   = 24'hFF_00_00;
  localparam rgb888_t GREEN = 24'h00_FF_00;
  localparam rgb888_t BLUE  = 24'h00_00_FF;

  function automatic int axis_total(input int sync, input int back, input int disp, input int front);
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/lcd_timing_drv_if.sv
// Pixel request bus between the timing driver (master) and a pixel source (slave).
interface lcd_timing_drv_if;
  import lcd_timing_pkg::*;

  // No valid/ready: every cycle the master presents a coordinate (0 when idle) and the
  // slave must return the matching registered pixel_data exactly one cycle later.
  rgb888_t           pixel_data;
  logic [CNT_W-1:0]  pixel_xpos;
  logic [CNT_W-1:0]  pixel_ypos;
  logic [CNT_W-1:0]  h_disp;
  logic [CNT_W-1:0]  v_disp;

  modport master (
    output pixel_xpos, pixel_ypos, h_disp, v_disp,
    input  pixel_data
  );

  modport slave (
    input  pixel_xpos, pixel_ypos, h_disp, v_disp,
    output pixel_data
  );

endinterface

// File: rtl/lcd_timing_drv_axis_cnt.sv
// Generic wrapping axis counter 0..TOTAL-1 with enable; wrap flags the enabled terminal cycle.
module lcd_axis_cnt
  import lcd_timing_pkg::*;
#(
  parameter int TOTAL = 525
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_timing_drv.sv
// Parallel-RGB LCD timing driver: HSYNC/VSYNC/DE generation and one-cycle-ahead pixel requests.
// Build option LCD_DE_ONLY_EN ties lcd_hs/lcd_vs high for DE-mode panels.
module lcd_timing_drv
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC  = P480_H_SYNC,
  parameter int H_BACK  = P480_H_BACK,
  parameter int H_DISP  = P480_H_DISP,
  parameter int H_FRONT = P480_H_FRONT,
  parameter int V_SYNC  = P480_V_SYNC,
  parameter int V_BACK  = P480_V_BACK,
  parameter int V_DISP  = P480_V_DISP,
  parameter int V_FRONT = P480_V_FRONT
) (
  input  logic                    lcd_pclk,
  input  logic                    rst_n,
  lcd_timing_drv_if.master        pix,
  output logic                    lcd_hs,
  output logic                    lcd_vs,
  output logic                    lcd_de,
  output rgb888_t                 lcd_rgb,
  output logic                    frame_start
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  generate
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || HA < 1 || H_DISP < 1 || V_DISP < 1) begin : g_bad_cfg
      $error("lcd_timing_drv: timing parameters do not fit the 11-bit counters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DE_BEG  = CNT_W'(HA);
  localparam logic [CNT_W-1:0] DE_END  = CNT_W'(HA + H_DISP);
  localparam logic [CNT_W-1:0] REQ_BEG = CNT_W'(HA - 1);
  localparam logic [CNT_W-1:0] REQ_END = CNT_W'(HA + H_DISP - 1);
  localparam logic [CNT_W-1:0] VA_BEG  = CNT_W'(VA);
  localparam logic [CNT_W-1:0] VA_END  = CNT_W'(VA + V_DISP);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             unused_v_wrap;
  logic             v_act;
  logic             data_req;

  lcd_axis_cnt #(.TOTAL(H_TOTAL)) u_h_cnt (
    .lcd_pclk (lcd_pclk),
    .rst_n    (rst_n),
    .en       (1'b1),
    .cnt      (h_cnt),
    .wrap     (h_wrap)
  );

  // Lines advance only on the horizontal wrap, so both axes wrap together at frame end.
  lcd_axis_cnt #(.TOTAL(V_TOTAL)) u_v_cnt (
    .lcd_pclk (lcd_pclk),
    .rst_n    (rst_n),
    .en       (h_wrap),
    .cnt      (v_cnt),
    .wrap     (unused_v_wrap)
  );

  // Everything below depends only on the counter registers, except the RGB gate.
  always_comb begin
    v_act       = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
    lcd_de      = v_act && (h_cnt >= DE_BEG) && (h_cnt < DE_END);
    data_req    = v_act && (h_cnt >= REQ_BEG) && (h_cnt < REQ_END);
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    lcd_rgb     = lcd_de ? pix.pixel_data : BLACK;
  end

`ifdef LCD_DE_ONLY_EN
  assign lcd_hs = 1'b1;
  assign lcd_vs = 1'b1;
`else
  assign lcd_hs = (h_cnt >= HS_END);
  assign lcd_vs = (v_cnt >= VS_END);
`endif

  assign pix.pixel_xpos = data_req ? (h_cnt - REQ_BEG) : '0;
  assign pix.pixel_ypos = data_req ? (v_cnt - VA_BEG) : '0;
  assign pix.h_disp     = CNT_W'(H_DISP);
  assign pix.v_disp     = CNT_W'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_drv.sv
// Self-checking bench for lcd_timing_drv using a reduced timing set so several frames fit in a short run.
module tb_lcd_timing_drv;
  import lcd_timing_pkg::*;

  localparam int H_SYNC  = 4;
  localparam int H_BACK  = 2;
  localparam int H_DISP  = 8;
  localparam int H_FRONT = 3;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 2;
  localparam int V_DISP  = 5;
  localparam int V_FRONT = 2;
  localparam int H_TOTAL = 17;
  localparam int V_TOTAL = 11;
  localparam int FRAME   = 187;
  localparam int HA      = 6;
  localparam int VA      = 4;

`ifdef LCD_DE_ONLY_EN
  localparam bit DE_ONLY = 1'b1;
`else
  localparam bit DE_ONLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic lcd_pclk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 lcd_pclk = ~lcd_pclk;

  lcd_timing_drv_if pix ();
  logic    lcd_hs, lcd_vs, lcd_de, frame_start;
  rgb888_t lcd_rgb;

  lcd_timing_drv #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT)
  ) dut (
    .lcd_pclk    (lcd_pclk),
    .rst_n       (rst_n),
    .pix         (pix),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .frame_start (frame_start)
  );

  // Pixel source: registers {row, column} of each request once.
  logic    force_ff = 1'b0;
  rgb888_t src_reg;
  always @(posedge lcd_pclk) src_reg <= {2'b00, pix.pixel_ypos, pix.pixel_xpos};
  assign pix.pixel_data = force_ff ? WHITE : src_reg;

  // ---------------- reference position ----------------
  int m_h, m_v;
  always @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_h <= 0;
      m_v <= 0;
    end else begin
      m_h <= (m_h == H_TOTAL - 1) ? 0 : m_h + 1;
      if (m_h == H_TOTAL - 1) m_v <= (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
    end
  end

  function automatic bit line_act();
    return (m_v >= VA) && (m_v < VA + V_DISP);
  endfunction
  function automatic bit exp_de();
    return line_act() && (m_h >= HA) && (m_h < HA + H_DISP);
  endfunction
  function automatic bit exp_req();
    return line_act() && (m_h >= HA - 1) && (m_h < HA + H_DISP - 1);
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", name, act, exp, m_h, m_v, $time);
    end
  endtask

  // Per-cycle timing check against the reference position.
  always @(negedge lcd_pclk) begin
    check("hs", lcd_hs, DE_ONLY ? 1 : (m_h >= H_SYNC));
    check("vs", lcd_vs, DE_ONLY ? 1 : (m_v >= V_SYNC));
    check("de", lcd_de, exp_de());
    check("xpos", pix.pixel_xpos, exp_req() ? m_h - (HA - 1) : 0);
    check("ypos", pix.pixel_ypos, exp_req() ? m_v - VA : 0);
    check("frame_start", frame_start, (m_h == 0) && (m_v == 0));
    check("h_disp", pix.h_disp, H_DISP);
    check("v_disp", pix.v_disp, V_DISP);
    if (!lcd_de) check("rgb_idle", lcd_rgb, 0);
  end

  // Request side: each issued coordinate pushes the pixel the panel must show next cycle.
  always @(negedge lcd_pclk) begin
    if (rst_n && exp_req())
      exp_q.push_back(force_ff ? WHITE : {2'b00, 11'(m_v - VA), 11'(m_h - (HA - 1))});
  end

  // Panel side: every DE cycle consumes one expected pixel.
  always @(negedge lcd_pclk) begin
    if (lcd_de) begin
      if (exp_q.size() == 0) check("rgb_underflow", 1, 0);
      else check("rgb_pixel", lcd_rgb, exp_q.pop_front());
    end
  end

  // Directed points: {h, v, xpos, ypos, de, hs, vs, frame_start}
  typedef struct { int h; int v; int x; int y; int de; int hs; int vs; int fs; } vec_t;
  vec_t vecs[13];
  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    vecs[1]  = '{3, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{4, 2, 0, 0, 0, 1, 1, 0};
    vecs[3]  = '{5, 4, 0, 0, 0, 1, 1, 0};
    vecs[4]  = '{6, 4, 1, 0, 1, 1, 1, 0};
    vecs[5]  = '{12, 4, 7, 0, 1, 1, 1, 0};
    vecs[6]  = '{13, 4, 0, 0, 1, 1, 1, 0};
    vecs[7]  = '{14, 4, 0, 0, 0, 1, 1, 0};
    vecs[8]  = '{5, 8, 0, 4, 0, 1, 1, 0};
    vecs[9]  = '{12, 8, 7, 4, 1, 1, 1, 0};
    vecs[10] = '{8, 3, 0, 0, 0, 1, 1, 0};
    vecs[11] = '{8, 9, 0, 0, 0, 1, 1, 0};
    vecs[12] = '{16, 10, 0, 0, 0, 1, 1, 0};
  end

  always @(negedge lcd_pclk) begin
    if (rst_n) begin
      for (int i = 0; i < 13; i++) begin
        if (vecs[i].h == m_h && vecs[i].v == m_v) begin
          check("vec_xpos", pix.pixel_xpos, vecs[i].x);
          check("vec_ypos", pix.pixel_ypos, vecs[i].y);
          check("vec_de", lcd_de, vecs[i].de);
          check("vec_hs", lcd_hs, DE_ONLY ? 1 : vecs[i].hs);
          check("vec_vs", lcd_vs, DE_ONLY ? 1 : vecs[i].vs);
          check("vec_fs", frame_start, vecs[i].fs);
        end
      end
    end
  end

  // Period, per-line DE and per-frame DE-line counters.
  int  fs_cnt, hs_cnt, vs_cnt, de_in_line, de_lines, hs_falls, vs_falls;
  bit  fs_seen, hs_seen, vs_seen, line_ok, frame_ok, prev_hs, prev_vs;
  always @(negedge lcd_pclk) begin
    if (!rst_n) begin
      fs_seen = 0; hs_seen = 0; vs_seen = 0; line_ok = 0; frame_ok = 0;
      prev_hs = lcd_hs; prev_vs = lcd_vs;
    end else begin
      fs_cnt++; hs_cnt++; vs_cnt++;
      if (frame_start) begin
        if (fs_seen) check("frame_period", fs_cnt, FRAME);
        fs_seen = 1; fs_cnt = 0;
      end
      if (prev_hs && !lcd_hs) begin
        if (hs_seen) check("hs_period", hs_cnt, H_TOTAL);
        hs_seen = 1; hs_cnt = 0; hs_falls++;
      end
      if (prev_vs && !lcd_vs) begin
        if (vs_seen) check("vs_period", vs_cnt, FRAME);
        vs_seen = 1; vs_cnt = 0; vs_falls++;
      end
      prev_hs = lcd_hs; prev_vs = lcd_vs;
      if (m_h == 0) begin
        de_in_line = 0; line_ok = 1;
        if (m_v == 0) begin de_lines = 0; frame_ok = 1; end
      end
      if (lcd_de) de_in_line++;
      if (m_h == H_TOTAL - 1 && line_ok) begin
        check("de_per_line", de_in_line, line_act() ? H_DISP : 0);
        if (de_in_line != 0) de_lines++;
        if (m_v == V_TOTAL - 1 && frame_ok) check("de_lines", de_lines, V_DISP);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos(input int h, input int v);
    bit ok = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge lcd_pclk);
      if (m_h == h && m_v == v) begin ok = 1; break; end
    end
    check("wait_pos_timeout", ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, lcd_hs, DE_ONLY ? 1 : 0);
    check({tag, "_vs"}, lcd_vs, DE_ONLY ? 1 : 0);
    check({tag, "_de"}, lcd_de, 0);
    check({tag, "_rgb"}, lcd_rgb, 0);
    check({tag, "_xpos"}, pix.pixel_xpos, 0);
    check({tag, "_ypos"}, pix.pixel_ypos, 0);
    check({tag, "_fs"}, frame_start, 1);
    check({tag, "_h_disp"}, pix.h_disp, H_DISP);
  endtask

  task automatic release_reset();
    @(posedge lcd_pclk);
    #1 rst_n = 1'b1;
    #1 check("first_cycle_fs", frame_start, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    #1 check_reset_outputs("por");
    release_reset();
    repeat (FRAME + 5) @(posedge lcd_pclk);

    // Saturated source for one whole frame: RGB must still be black outside DE.
    wait_pos(5, 0);
    force_ff = 1'b1;
    repeat (FRAME) @(negedge lcd_pclk);
    force_ff = 1'b0;

    // Mid-frame reset while a pixel is on the bus.
    wait_pos(9, 6);
    check("pre_reset_de", lcd_de, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    exp_q.delete();
    repeat (3) @(posedge lcd_pclk);
    release_reset();
    repeat (2 * FRAME + 10) @(posedge lcd_pclk);

    if (!DE_ONLY) begin
      check("hs_falls_seen", hs_falls > 2, 1);
      check("vs_falls_seen", vs_falls > 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
